reg_file: RTL and testbench



---
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Integer register file: 31 storage registers plus hardwired-zero x0, two
// combinational read ports with write-first bypass, and a pending scoreboard.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(NREG)-1:0] rd_exu,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_ready,
  output logic                    rs2_ready
);

  localparam int IW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic            wr_active;
  logic            claim_active;

  assign wr_active    = (rd != '0);
  assign claim_active = (rd_exu != '0);

  // Retirement clears first so a same-cycle claim of the same register wins.
  always_comb begin
    pending_next = pending;
    if (wr_active) begin
      pending_next[rd] = 1'b0;
    end
    if (claim_active) begin
      pending_next[rd_exu] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[rd] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Bypass is gated by reset so every read returns zero/ready while held.
  function automatic logic [XLEN:0] read_port(input logic [IW-1:0] idx);
    logic [XLEN:0] result;
    result = {1'b1, {XLEN{1'b0}}};
    if (!rst_n || idx == '0) begin
      result = {1'b1, {XLEN{1'b0}}};
    end else if (idx == rd) begin
      result = {1'b1, in_data};
    end else begin
      result = {~pending[idx], regs[idx]};
    end
    return result;
  endfunction

  always_comb begin
    {rs1_ready, rs1_data} = read_port(rs1);
    {rs2_ready, rs2_data} = read_port(rs2);
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed checks with literal expectations
// followed by randomized traffic compared every cycle against an array model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd, rd_exu;
  logic [31:0] in_data;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_ready, rs2_ready;

  int checks;
  int failures;
  bit check_en;

  logic [31:0] model_regs [32];
  bit          model_pend [32];

  reg_file #(.XLEN(32), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .in_data   (in_data),
    .rd_exu    (rd_exu),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rs1_ready (rs1_ready),
    .rs2_ready (rs2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      model_pend[i] = 1'b0;
    end
  endtask

  // Architectural state as the write-back and claim rules describe it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clearModel();
    end else begin
      if (rd != 0) begin
        model_regs[rd] = in_data;
        model_pend[rd] = 1'b0;
      end
      if (rd_exu != 0) model_pend[rd_exu] = 1'b1;
    end
  end

  function automatic logic [32:0] expectRead(input logic [4:0] idx);
    if (!rst_n || idx == 0) return {1'b1, 32'h0};
    if (idx == rd) return {1'b1, in_data};
    return {~model_pend[idx], model_regs[idx]};
  endfunction

  task automatic compareOne(input string name, input logic [31:0] act_d,
                            input logic act_r, input logic [31:0] exp_d,
                            input logic exp_r);
    checks++;
    if (act_d !== exp_d || act_r !== exp_r) begin
      failures++;
      $display("[TB] FAIL %s: got data=%h ready=%b, expected data=%h ready=%b (t=%0t)",
               name, act_d, act_r, exp_d, exp_r, $time);
    end
  endtask

  // Model comparison, mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    logic [32:0] e1, e2;
    if (check_en) begin
      e1 = expectRead(rs1);
      e2 = expectRead(rs2);
      compareOne("model_rs1", rs1_data, rs1_ready, e1[31:0], e1[32]);
      compareOne("model_rs2", rs2_data, rs2_ready, e2[31:0], e2[32]);
    end
  end

  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic [4:0] e,
                               input logic [31:0] dat);
    @(posedge clk);
    #1;
    rs1 = a; rs2 = b; rd = d; rd_exu = e; in_data = dat;
  endtask

  task automatic checkOutput(input string name,
                             input logic [31:0] d1, input logic r1,
                             input logic [31:0] d2, input logic r2);
    #1;
    compareOne({name, "_rs1"}, rs1_data, rs1_ready, d1, r1);
    compareOne({name, "_rs2"}, rs2_data, rs2_ready, d2, r2);
  endtask

  initial begin
    checks = 0; failures = 0; check_en = 1'b0;
    clearModel();
    rst_n = 1'b0;
    rs1 = 0; rs2 = 0; rd = 0; rd_exu = 0; in_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      checkOutput("reset_sweep", 32'h0, 1'b1, 32'h0, 1'b1);
    end

    applyStimulus(0, 0, 0, 0, 32'hFFFFFFFF);
    checkOutput("x0_idle_write", 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("x0_after", 32'h0, 1'b1, 32'h0, 1'b1);

    applyStimulus(1, 2, 2, 0, 32'hF0F0FEEC);
    checkOutput("bypass_x2", 32'h0, 1'b1, 32'hF0F0FEEC, 1'b1);
    applyStimulus(1, 2, 0, 0, 0);
    checkOutput("stored_x2", 32'h0, 1'b1, 32'hF0F0FEEC, 1'b1);

    applyStimulus(2, 2, 0, 2, 0);
    checkOutput("claim_same_cycle", 32'hF0F0FEEC, 1'b1, 32'hF0F0FEEC, 1'b1);
    applyStimulus(2, 2, 0, 0, 0);
    checkOutput("claim_pending", 32'hF0F0FEEC, 1'b0, 32'hF0F0FEEC, 1'b0);
    applyStimulus(2, 0, 2, 0, 32'h0ECCCCCC);
    checkOutput("release_bypass", 32'h0ECCCCCC, 1'b1, 32'h0, 1'b1);
    applyStimulus(2, 0, 0, 0, 0);
    checkOutput("release_after", 32'h0ECCCCCC, 1'b1, 32'h0, 1'b1);

    applyStimulus(0, 3, 3, 3, 32'h0ECCCCCC);
    checkOutput("set_wins_bypass", 32'h0, 1'b1, 32'h0ECCCCCC, 1'b1);
    applyStimulus(0, 3, 0, 0, 0);
    checkOutput("set_wins_after", 32'h0, 1'b1, 32'h0ECCCCCC, 1'b0);
    applyStimulus(0, 3, 3, 0, 32'h11111111);
    checkOutput("x3_rewrite", 32'h0, 1'b1, 32'h11111111, 1'b1);
    applyStimulus(0, 3, 0, 0, 0);
    checkOutput("x3_cleared", 32'h0, 1'b1, 32'h11111111, 1'b1);

    applyStimulus(0, 7, 7, 0, 32'hDEADBEEF);
    applyStimulus(7, 7, 0, 0, 0);
    checkOutput("dual_port_x7", 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1);

    applyStimulus(5, 5, 5, 5, 32'h12345678);
    applyStimulus(5, 0, 0, 0, 0);
    checkOutput("x5_claimed", 32'h12345678, 1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    checkOutput("async_reset", 32'h0, 1'b1, 32'h0, 1'b1);
    rd = 5; rs1 = 5; in_data = 32'hA5A5A5A5;
    checkOutput("reset_no_bypass", 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    rd = 0;
    rst_n = 1'b1;

    // Randomized traffic; the negedge process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(5'($urandom), 5'($urandom),
                    ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom),
                    ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom),
                    $urandom);
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
